lsu_mem_responder: RTL and testbench

- Bus-side responder for the LSU load/store request interface; the target end of LSU load/store traffic.
- Accepts level-held read requests (araddr/arvalid/rstrb) and write requests (awaddr/awvalid/wdata/wstrb/wvalid).
- Serves requests from an internal word-organised SRAM after programmable latencies, returning a one-cycle rvalid or wready pulse.
- Used as the data-memory model behind the LSU in simulation and as a small on-chip scratchpad.

---
 rtl/lsu_mem_responder.sv | 219 +++++++++++++++++++++
 tb/tb_lsu_mem_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_responder.sv
// ---------------------------------------------------------------------------
// lsu_mem_responder
//
// Target end of the LSU load/store request interface. The requester holds a
// read (araddr/arvalid/rstrb) or a write (awaddr/awvalid/wdata/wstrb/wvalid)
// at a steady level. This block accepts it, waits a programmable latency, and
// answers with a single-cycle lsu_rvalid or lsu_wready pulse. Data lives in a
// word-organised SRAM that is split into one byte-wide bank per lane.
//
// Use: data-memory model behind the LSU in simulation, or a small on-chip
// scratchpad.
//
// Ports
//   clk, rstn      clock, synchronous active-low reset
//   lsu_araddr     read byte address
//   lsu_arvalid    read request, held until rvalid
//   lsu_rstrb      read size strobe (1/3/f), used only for the misalign check
//   lsu_rdata      full aligned word, unshifted; holds until the next read
//   lsu_rvalid     read response pulse
//   lsu_awaddr     write byte address
//   lsu_awvalid    write address valid
//   lsu_wdata      right-justified write data
//   lsu_wstrb      right-justified write strobe (1/3/f)
//   lsu_wvalid     write data valid
//   lsu_wready     write completion pulse
//   resp_err       qualifies rvalid/wready: out of range or lane crossing
// ---------------------------------------------------------------------------

// One byte lane of the SRAM. Its read register captures only at the start of
// a read response, so lsu_rdata holds its value between reads. The register
// is zeroed when the read is in error.
module lsu_mem_responder_lane #(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [MEM_AW-1:0] idx,
    input  logic              we,
    input  logic [7:0]        wbyte,
    input  logic              rd_en,
    input  logic              rd_clr,
    output logic [7:0]        rbyte
);
    logic [7:0] mem [2**MEM_AW];

    // The array has no reset. Its contents survive rstn.
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wbyte;
    end

    always_ff @(posedge clk) begin
        if (!rstn)       rbyte <= 8'h00;
        else if (rd_en)  rbyte <= rd_clr ? 8'h00 : mem[idx];
    end
endmodule

module lsu_mem_responder #(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter int              MEM_AW    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000,
    parameter int              RD_LAT    = 2,
    parameter int              WR_LAT    = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    input  logic [7:0]        lsu_rstrb,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rvalid,
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic              lsu_awvalid,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wstrb,
    input  logic              lsu_wvalid,
    output logic              lsu_wready,
    output logic              resp_err
);
    localparam int NUM_LANES = DATA_W / 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_WAIT = 3'd1;
    localparam logic [2:0] S_RD_RESP = 3'd2;
    localparam logic [2:0] S_WR_WAIT = 3'd3;
    localparam logic [2:0] S_WR_RESP = 3'd4;

    localparam logic [3:0] RD_CNT0 = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_CNT0 = 4'(WR_LAT - 1);

    // Window size in bytes. It is one bit wider than the address so the
    // upper-bound compare uses the full offset and cannot alias.
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(1) << (MEM_AW + 2);

    logic [2:0]        state, state_d;
    logic [3:0]        cnt, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        strb_q;
    logic [DATA_W-1:0] wdata_q;

    logic              acc_wr, acc_rd;
    logic [ADDR_W-1:0] cur_addr;
    logic [7:0]        cur_strb;
    logic [ADDR_W-1:0] off;
    logic [1:0]        lane;
    logic [11:0]       strb_sh;
    logic              in_range, err;
    logic [MEM_AW-1:0] idx;
    logic [NUM_LANES-1:0] be;
    logic [DATA_W-1:0] wdata_sh;
    logic              rd_capture, wr_commit;

    // ---------------- accept and request source ----------------
    // With LAT==1 the response begins on the accept edge itself. Decode must
    // then look at the live inputs, because the request registers are not
    // loaded yet. In every other state it looks at the captured request.
    always_comb begin
        acc_wr   = (state == S_IDLE) && lsu_awvalid && lsu_wvalid;
        acc_rd   = (state == S_IDLE) && !acc_wr && lsu_arvalid;
        cur_addr = addr_q;
        cur_strb = strb_q;
        if (acc_wr) begin
            cur_addr = lsu_awaddr;
            cur_strb = lsu_wstrb;
        end else if (acc_rd) begin
            cur_addr = lsu_araddr;
            cur_strb = lsu_rstrb;
        end
    end

    // ---------------- address decode / lane alignment ----------------
    always_comb begin
        off      = cur_addr - BASE_ADDR;
        in_range = (cur_addr >= BASE_ADDR) && ({1'b0, off} < MEM_BYTES);
        lane     = cur_addr[1:0];
        // Any strobe bit pushed beyond lane 3 marks a lane-crossing access.
        strb_sh  = {4'b0000, cur_strb} << lane;
        err      = !in_range || (|strb_sh[11:4]);
        idx      = off[MEM_AW+1:2];
        be       = strb_sh[NUM_LANES-1:0];
        wdata_sh = wdata_q << {lane, 3'b000};
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            S_IDLE: begin
                if (acc_wr) begin
                    cnt_d   = WR_CNT0;
                    state_d = (WR_LAT == 1) ? S_WR_RESP : S_WR_WAIT;
                end else if (acc_rd) begin
                    cnt_d   = RD_CNT0;
                    state_d = (RD_LAT == 1) ? S_RD_RESP : S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                cnt_d = cnt - 4'd1;
                if (cnt <= 4'd1) state_d = S_RD_RESP;
            end
            S_WR_WAIT: begin
                cnt_d = cnt - 4'd1;
                if (cnt <= 4'd1) state_d = S_WR_RESP;
            end
            S_RD_RESP, S_WR_RESP: state_d = S_IDLE;
            default:              state_d = S_IDLE;
        endcase
    end

    // Read data is captured on the edge that enters RD_RESP, so it is valid
    // together with rvalid. A write commits on the edge that leaves WR_RESP.
    // rstn gates that commit, so a reset in that cycle drops the write.
    assign rd_capture = (state_d == S_RD_RESP);
    assign wr_commit  = (state == S_WR_RESP) && !err && rstn;

    // ---------------- state and outputs ----------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            lsu_rvalid <= 1'b0;
            lsu_wready <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            lsu_rvalid <= (state_d == S_RD_RESP);
            lsu_wready <= (state_d == S_WR_RESP);
            resp_err   <= ((state_d == S_RD_RESP) || (state_d == S_WR_RESP)) && err;
        end
    end

    // Request capture. Inputs are not sampled again after accept.
    always_ff @(posedge clk) begin
        if (acc_wr) begin
            addr_q  <= lsu_awaddr;
            strb_q  <= lsu_wstrb;
            wdata_q <= lsu_wdata;
        end else if (acc_rd) begin
            addr_q  <= lsu_araddr;
            strb_q  <= lsu_rstrb;
        end
    end

    // ---------------- SRAM byte lanes ----------------
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lsu_mem_responder_lane #(.MEM_AW(MEM_AW)) u_lane (
            .clk   (clk),
            .rstn  (rstn),
            .idx   (idx),
            .we    (wr_commit && be[g]),
            .wbyte (wdata_sh[8*g +: 8]),
            .rd_en (rd_capture),
            .rd_clr(err),
            .rbyte (lsu_rdata[8*g +: 8])
        );
    end
endmodule

// File: tb/tb_lsu_mem_responder.sv
module tb_lsu_mem_responder;
    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] araddr, awaddr, wdata;
    logic        arvalid, awvalid, wvalid;
    logic [7:0]  rstrb, wstrb;
    logic [31:0] rdata1, rdata2;
    logic        rvalid1, wready1, err1, rvalid2, wready2, err2;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        is_wr;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    // Byte-addressed reference memory
    logic [7:0] mdl [logic [31:0]];

    always #5 clk = ~clk;

    lsu_mem_responder #(.RD_LAT(2), .WR_LAT(1)) u_dut (
        .clk(clk), .rstn(rstn),
        .lsu_araddr(araddr), .lsu_arvalid(arvalid), .lsu_rstrb(rstrb),
        .lsu_rdata(rdata1), .lsu_rvalid(rvalid1),
        .lsu_awaddr(awaddr), .lsu_awvalid(awvalid), .lsu_wdata(wdata),
        .lsu_wstrb(wstrb), .lsu_wvalid(wvalid), .lsu_wready(wready1),
        .resp_err(err1)
    );

    lsu_mem_responder #(.RD_LAT(3), .WR_LAT(3)) u_dut2 (
        .clk(clk), .rstn(rstn),
        .lsu_araddr(araddr), .lsu_arvalid(arvalid), .lsu_rstrb(rstrb),
        .lsu_rdata(rdata2), .lsu_rvalid(rvalid2),
        .lsu_awaddr(awaddr), .lsu_awvalid(awvalid), .lsu_wdata(wdata),
        .lsu_wstrb(wstrb), .lsu_wvalid(wvalid), .lsu_wready(wready2),
        .resp_err(err2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_err(input logic [31:0] a, input logic [7:0] s);
        int sz;
        bit inr;
        sz  = (s == 8'h0f) ? 4 : (s == 8'h03) ? 2 : 1;
        inr = (a >= 32'h8000_0000) && (a < 32'h8000_1000);
        return !inr || (int'(a[1:0]) + sz > 4);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] b;
        w = 32'h0;
        b = {a[31:2], 2'b00};
        for (int j = 0; j < 4; j++)
            w[8*j +: 8] = mdl.exists(b + j) ? mdl[b + j] : 8'h00;
        return w;
    endfunction

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
        bit e;
        e = m_err(a, s);
        sb.push_back('{1'b1, 32'h0, e});
        if (!e)
            for (int i = 0; i < 4; i++)
                if (s[i]) mdl[a + i] = d[8*i +: 8];
    endtask

    task automatic push_rd(input logic [31:0] a, input logic [7:0] s);
        bit e;
        e = m_err(a, s);
        sb.push_back('{1'b0, e ? 32'h0 : m_read(a), e});
    endtask

    function automatic logic pulse(input int dut, input bit is_wr);
        if (dut == 1) return is_wr ? wready1 : rvalid1;
        return is_wr ? wready2 : rvalid2;
    endfunction

    // Count edges until the response pulse. Then pop the scoreboard and check.
    task automatic wait_resp(input int dut, input bit is_wr, input int lat, input string tag);
        int   n;
        logic hit;
        exp_t e;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 40) begin
            @(posedge clk); #1;
            n++;
            hit = pulse(dut, is_wr);
        end
        chk({tag, " latency"}, n, lat);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, observed a response expected none", tag);
        end else begin
            e = sb.pop_front();
            if (hit) begin
                if (!is_wr) chk({tag, " rdata"}, (dut == 1) ? rdata1 : rdata2, e.data);
                chk({tag, " resp_err"}, (dut == 1) ? err1 : err2, e.err);
            end
        end
    endtask

    task automatic do_wr(input int dut, input int lat, input logic [31:0] a,
                         input logic [31:0] d, input logic [7:0] s, input string tag);
        @(negedge clk);
        push_wr(a, d, s);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        wait_resp(dut, 1'b1, lat, tag);
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        chk({tag, " one-cycle"}, pulse(dut, 1'b1), 1'b0);
    endtask

    task automatic do_rd(input int dut, input int lat, input logic [31:0] a,
                         input logic [7:0] s, input string tag);
        @(negedge clk);
        push_rd(a, s);
        araddr = a; rstrb = s; arvalid = 1'b1;
        wait_resp(dut, 1'b0, lat, tag);
        arvalid = 1'b0;
        @(posedge clk); #1;
        chk({tag, " one-cycle"}, pulse(dut, 1'b0), 1'b0);
    endtask

    initial begin
        rstn = 1'b0;
        araddr = '0; awaddr = '0; wdata = '0; rstrb = '0; wstrb = '0;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rstn = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle outputs", {rvalid1, wready1, err1}, 3'b000);
        end
        chk("idle rdata", rdata1, 32'h0);

        // Word write, then read back
        do_wr(1, 1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0f, "sw");
        do_rd(1, 2, 32'h8000_0010, 8'h0f, "lw");

        // Byte and half lanes
        do_wr(1, 1, 32'h8000_0013, 32'h0000_0011, 8'h01, "sb lane3");
        do_wr(1, 1, 32'h8000_0010, 32'h0000_2233, 8'h03, "sh lane0");
        do_rd(1, 2, 32'h8000_0010, 8'h0f, "lw merged");

        // Range boundaries and lane-1 byte; reads return the unshifted word
        do_wr(1, 1, 32'h8000_0000, 32'hA5A5_A5A5, 8'h0f, "sw first word");
        do_wr(1, 1, 32'h8000_0FFC, 32'h0102_0304, 8'h0f, "sw last word");
        do_wr(1, 1, 32'h8000_0FFD, 32'h0000_00EE, 8'h01, "sb lane1");
        do_rd(1, 2, 32'h8000_0FFE, 8'h03, "lh last word");

        // Error cases: a pulse still comes back, and memory is unchanged
        do_wr(1, 1, 32'h8000_0013, 32'h0000_FFFF, 8'h03, "sh crossing");
        do_rd(1, 2, 32'h8000_0010, 8'h0f, "lw after crossing");
        do_rd(1, 2, 32'h7FFF_FFFC, 8'h0f, "lw below range");
        do_wr(1, 1, 32'h8000_1000, 32'h5A5A_5A5A, 8'h0f, "sw above range");
        do_rd(1, 2, 32'h8000_0000, 8'h0f, "lw first word kept");
        do_rd(1, 2, 32'h8000_0012, 8'h0f, "lw misaligned");

        // Simultaneous write and read: the write goes first, then the held read repeats
        @(negedge clk);
        push_wr(32'h8000_0010, 32'h0BAD_F00D, 8'h0f);
        push_rd(32'h8000_0010, 8'h0f);
        push_rd(32'h8000_0010, 8'h0f);
        awaddr = 32'h8000_0010; wdata = 32'h0BAD_F00D; wstrb = 8'h0f;
        araddr = 32'h8000_0010; rstrb = 8'h0f;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        wait_resp(1, 1'b1, 1, "simul wr");
        awvalid = 1'b0; wvalid = 1'b0;
        wait_resp(1, 1'b0, 3, "held rd1");
        wait_resp(1, 1'b0, 3, "held rd2");
        arvalid = 1'b0;
        @(posedge clk); #1;
        chk("held rd one-cycle", rvalid1, 1'b0);

        // Reset during RD_WAIT
        @(negedge clk);
        araddr = 32'h8000_0010; rstrb = 8'h0f; arvalid = 1'b1;
        @(posedge clk); #1;
        chk("rst rd accept", rvalid1, 1'b0);
        @(negedge clk); rstn = 1'b0; arvalid = 1'b0;
        @(posedge clk); #1;
        chk("rst rd no pulse", rvalid1, 1'b0);
        chk("rst rd rdata cleared", rdata1, 32'h0);
        @(negedge clk); rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst rd quiet", rvalid1, 1'b0);
        end
        do_rd(1, 2, 32'h8000_0010, 8'h0f, "lw after rst");

        // Second instance, latency 3: aborted write during WR_WAIT
        @(negedge clk); rstn = 1'b0;
        @(negedge clk); rstn = 1'b1;
        do_wr(2, 3, 32'h8000_0020, 32'hCAFE_F00D, 8'h0f, "d2 sw");
        @(negedge clk);
        awaddr = 32'h8000_0020; wdata = 32'h1234_5678; wstrb = 8'h0f;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        chk("d2 abort accept", wready2, 1'b0);
        @(negedge clk); rstn = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        chk("d2 abort in reset", wready2, 1'b0);
        @(negedge clk); rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("d2 abort no pulse", wready2, 1'b0);
        end
        do_rd(2, 3, 32'h8000_0020, 8'h0f, "d2 lw after abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
